// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: instruction-memory request/response and decode valid/ready
// handshakes of the fetch unit.
interface ifu_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_npc;

    modport master (
        output im_req, im_addr, inst_valid, inst, inst_pc, inst_npc,
        input  im_gnt, im_rvalid, im_rdata, inst_ready
    );

    modport slave (
        input  im_req, im_addr, inst_valid, inst, inst_pc, inst_npc,
        output im_gnt, im_rvalid, im_rdata, inst_ready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-limited instruction fetch with a DEPTH-entry prefetch FIFO
// and redirect flush. Define IFU_STATS_EN to add the stat_fetch/stat_flush counters.
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    ifu_prefetch_if.master    bus,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
`ifdef IFU_STATS_EN
    ,
    output logic [31:0]       stat_fetch,
    output logic [31:0]       stat_flush
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] PC_MASK  = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(32'd1);
    localparam logic [CNT_W:0]    CREDIT   = (CNT_W+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  drop_r;

    logic              credit_s;
    logic              req_s;
    logic              issue_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic [CNT_W-1:0]  rsp_dec_s;
    logic [ADDR_W-1:0] redirect_addr_s;

    // Handshake qualifiers; in-flight requests plus buffered words never exceed DEPTH
    always_comb begin
        credit_s        = ({1'b0, outstanding_r} + {1'b0, count_r}) < CREDIT;
        req_s           = !rst && !redirect && credit_s;
        issue_s         = req_s && bus.im_gnt;
        pop_s           = (count_r != CNT_ZERO) && bus.inst_ready;
        drop_s          = bus.im_rvalid && (drop_r != CNT_ZERO);
        push_s          = bus.im_rvalid && (drop_r == CNT_ZERO) && !redirect;
        rsp_dec_s       = CNT_W'(bus.im_rvalid);
        redirect_addr_s = redirect_pc & PC_MASK;
    end

    // PC, FIFO and counter state; a redirect turns every still-outstanding request stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            outstanding_r <= CNT_ZERO;
            drop_r        <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= {ADDR_W{1'b0}};
                inst_q[i] <= {DATA_W{1'b0}};
            end
        end else if (redirect) begin
            fetch_pc_r    <= redirect_addr_s;
            resp_pc_r     <= redirect_addr_s;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            outstanding_r <= outstanding_r - rsp_dec_s;
            drop_r        <= outstanding_r - rsp_dec_s;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (push_s) begin
                pc_q[wr_ptr_r]   <= resp_pc_r;
                inst_q[wr_ptr_r] <= bus.im_rdata;
                wr_ptr_r         <= wr_ptr_r + PTR_ONE;
                resp_pc_r        <= resp_pc_r + PC_STEP;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r       <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            drop_r        <= drop_r - CNT_W'(drop_s);
            outstanding_r <= outstanding_r + CNT_W'(issue_s) - rsp_dec_s;
        end
    end

    assign bus.im_req     = req_s;
    assign bus.im_addr    = fetch_pc_r;
    assign bus.inst_valid = (count_r != CNT_ZERO);
    assign bus.inst       = inst_q[rd_ptr_r];
    assign bus.inst_pc    = pc_q[rd_ptr_r];
    assign bus.inst_npc   = pc_q[rd_ptr_r] + PC_STEP;
    assign busy           = (outstanding_r != CNT_ZERO) || (count_r != CNT_ZERO);

`ifdef IFU_STATS_EN
    logic [31:0] stat_fetch_r;
    logic [31:0] stat_flush_r;

    // Pop and redirect-cycle event counters, free-running with silent wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetch_r <= 32'd0;
            stat_flush_r <= 32'd0;
        end else begin
            stat_fetch_r <= stat_fetch_r + 32'(pop_s);
            stat_flush_r <= stat_flush_r + 32'(redirect);
        end
    end

    assign stat_fetch = stat_fetch_r;
    assign stat_flush = stat_flush_r;
`endif
endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit for the MIPS core, succeeding the fixed PC register and PC+4 adder with a free-running, buffered fetch stage. It owns the PC, issues word requests to instruction memory under a grant/response handshake, and buffers returned words in a DEPTH-entry prefetch FIFO. It presents them to decode with a valid/ready handshake. A redirect from branch/jump/jr resolution flushes the buffer and discards stale in-flight responses.

## Interface
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries and maximum in-flight requests; power of two, ≥2
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- im_req  out  1  fetch request valid
- im_addr  out  ADDR_W  fetch address, word aligned
- im_gnt  in  1  memory accepts request this cycle
- im_rvalid  in  1  in-order response valid, ≥1 cycle after its grant
- im_rdata  in  DATA_W  response word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored and forced to 0
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst  out  DATA_W  head instruction
- inst_pc  out  ADDR_W  address of head instruction
- inst_npc  out  ADDR_W  inst_pc + 4, used for link and branch base
- busy  out  1  requests in flight or FIFO non-empty

## Operation
- State:
  - fetch_pc (next address to request)
  - resp_pc (address of next accepted response)
  - FIFO of {pc, inst}, DEPTH entries
  - outstanding counter, 0..DEPTH
  - drop counter, 0..DEPTH
- Credit rule: im_req = !redirect && (outstanding + fifo_count < DEPTH); im_addr = fetch_pc.
- Issue: im_req && im_gnt → fetch_pc += 4 (mod 2^ADDR_W, wrap silent), outstanding++.
- Response with drop == 0 and no redirect: push {resp_pc, im_rdata}, resp_pc += 4, outstanding--.
- Response with drop > 0: discard, drop--, outstanding--.
- Pop: inst_valid && inst_ready removes the head.
- Redirect:
  - fetch_pc and resp_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}.
  - FIFO cleared.
  - drop ← outstanding minus any response arriving the same cycle (that response is discarded).
  - A pop in the same cycle still counts as consumed.
  - outstanding is unaffected except by the response in that cycle.
- Counters never exceed DEPTH by construction; overflow is not a reachable state.
- No mid-response protocol errors are handled: rvalid with outstanding == 0 is illegal and the bench asserts it never occurs.

## Timing
- Reset values:
  - fetch_pc = resp_pc = RESET_PC
  - im_req = 0 while rst is high
  - inst_valid = 0, busy = 0
  - all counters 0
- First im_req is in the first cycle after rst falls.
- Response-to-decode latency is 1 cycle with no bypass: rvalid at edge T → inst_valid after edge T.
- Redirect asserted in cycle T:
  - im_req is low in T.
  - im_addr = redirect_pc in T+1.
  - inst_valid is low from T+1 until the first new response is pushed.
- Steady state with im_gnt = 1, 1-cycle memory and inst_ready = 1: one instruction per cycle.
- Async reset mid-operation clears all state immediately. Responses arriving after reset release for pre-reset requests are outside the protocol; memory must also be reset.

## Configuration
- IFU_STATS_EN defined:
  - adds outputs stat_fetch (out, 32) and stat_flush (out, 32).
  - stat_fetch counts pops; stat_flush counts redirect cycles.
  - Both reset to 0 and wrap at 2^32.
- IFU_STATS_EN undefined: neither port nor counters exist; behaviour otherwise identical.

## Test plan
- Reset/stream: RESET_PC = 0x00400000, gnt = 1, 1-cycle memory, ready = 1 → inst_pc 0x00400000, 0x00400004, … every cycle; inst_npc = inst_pc + 4; first inst_valid 2 cycles after rst falls.
- Backpressure: ready = 0, DEPTH = 4 → exactly 4 grants then im_req low; ready = 1 drains 4 words in order, then fetch resumes at 0x00400010.
- Flush with in-flight: 3-cycle memory, 2 outstanding, redirect_pc = 0x00000103 → both stale responses dropped; next inst_pc = 0x00000100; im_addr = 0x00000100 the cycle after redirect.
- Simultaneous events: redirect in the same cycle as a pop and an rvalid → popped word counted consumed, arriving word discarded, drop = outstanding − 1, FIFO empty after the edge.
- Wrap/reset: fetch_pc = 0xFFFFFFFC → next im_addr 0x00000000; rst pulsed mid-stream → inst_valid = 0 and im_req = 0 immediately, restart at RESET_PC.
- With IFU_STATS_EN: 10 pops and 2 redirects → stat_fetch = 10, stat_flush = 2; both 0 after rst.
